morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive-side counterpart of the switch-driven Morse blinker: a single key line carries hand-keyed Morse for letters A–H.
- The block times each press and each gap, classifies presses as dot or dash, and detects the end of a letter.
- It then emits the 3-bit letter code using the same encoding as the blinker's SW[2:0] (000=A … 111=H).
- Sits between a board pushbutton/switch (inverted as needed by the top level) and LEDR/HEX display logic.

Parameters:
- UNIT_CYCLES, 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); must be ≥2.
- CNT_W, 32, width of the duration counter; must hold 3*UNIT_CYCLES.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- morse_in  input  1  asynchronous key level, 1 = key down (mark).
- letter  output  3  last successfully decoded letter, 000=A … 111=H.
- letter_valid  output  1  one-cycle pulse when `letter` has been updated.
- letter_error  output  1  one-cycle pulse when a completed symbol group is not A–H or exceeds 4 symbols.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Input path
  - morse_in passes through a 2-flop synchronizer; all timing uses the synchronized level `m`.
  - This adds fixed 2-cycle latency and does not change measured durations.
- Reset
  - letter=000, letter_valid=0, letter_error=0, busy=0.
  - State=IDLE; synchronizer flops, counter, symbol register, symbol count and overflow flag all cleared.
  - armed=0.
  - Reset asserted mid-letter discards the partial letter with no pulse.
- Arming
  - armed sets on the first cycle with m=0 after reset.
  - A key held down through reset release is ignored until released.
- Counter behaviour: cnt saturates at all-ones and never wraps.
- State IDLE
  - Entered with symbol count n=0.
  - On m=1 and armed=1 → MARK, cnt=1.
- State MARK
  - cnt increments each cycle while m=1.
  - On m=0 the press is classified on the final cnt value d (number of high cycles):
    - dot if d < 2*UNIT_CYCLES;
    - dash if d ≥ 2*UNIT_CYCLES.
  - Append the symbol: sym <= {sym[2:0], is_dash}, n <= n+1.
  - If n was already 4, do not shift; set ovf=1 instead.
  - → SPACE with cnt=1.
- State SPACE
  - cnt increments while m=0.
  - If m=1 before cnt reaches 3*UNIT_CYCLES → MARK, cnt=1 (intra-letter gap; symbols kept).
  - When cnt == 3*UNIT_CYCLES (the 3U-th consecutive low cycle): decode, go to IDLE, clear sym/n/ovf.
  - The pulse appears on the following cycle.
  - If m rises on that same cycle, decode still wins; the rise is taken from IDLE on the next cycle.
- Decode table (n, sym[n-1:0], first symbol in MSB, 1 = dash):
  - A: 2, 01
  - B: 4, 1000
  - C: 4, 1010
  - D: 3, 100
  - E: 1, 0
  - F: 4, 0010
  - G: 3, 110
  - H: 4, 0000
- Decode outputs
  - On a match with ovf=0: letter <= code and letter_valid pulses for 1 cycle.
  - Otherwise: letter_error pulses for 1 cycle and letter holds its old value.
  - letter_valid and letter_error are never high together.
- Latency: the valid/error pulse rises 3*UNIT_CYCLES+1 cycles after the last falling edge of m.
- busy=1 in MARK and SPACE.

Test Plan (UNIT_CYCLES=4, all durations in cycles of `m`):
- A: high 3, low 4, high 8, low 12.
  - Required: letter_valid pulse exactly 1 cycle, 13 cycles after the final fall; letter=000.
  - Required: busy drops to 0 in the same cycle the pulse appears.
- Dot/dash boundary, part 1: high 7 then low 12 → E, letter=100.
- Dot/dash boundary, part 2: high 8 then low 12 → dash alone (T, not in table).
  - Required: letter_error pulse; letter stays 100.
- H, then gap boundary:
  - Four dots (high 2 / low 4) → letter=111.
  - Dot, low 11, dash, low 12 → a single letter A (000), not E plus error.
- Overflow: five dots, then low 12 → single letter_error pulse, no letter_valid.
  - Next letter D (dash, dot, dot) decodes cleanly to 011.
- Reset cases:
  - Reset for 1 cycle midway through a B → no pulse, busy=0; a following C decodes to 010.
  - Hold morse_in=1 across reset release for 20 cycles, then release and idle → no pulse; state stays IDLE.

Source files
------------

// File: rtl/morse_decoder.sv
// Hand-keyed Morse receiver for letters A-H.
// Times marks and gaps, classifies dot/dash and emits a 3-bit letter code.
module morse_decoder #(
  parameter int UNIT_CYCLES = 25000000,
  parameter int CNT_W       = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       letter_error,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             primed_q, primed_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sym_q, sym_d;
  logic [2:0]       n_q, n_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic             m;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_dash;
  logic             hit;
  logic [2:0]       code;

  assign m       = s2_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign is_dash = (cnt_q >= DASH_MIN);

  always_comb begin
    hit  = 1'b0;
    code = 3'd0;
    unique case (n_q)
      3'd1: begin
        if (sym_q[0] == 1'b0) begin
          hit  = 1'b1;
          code = 3'd4;
        end
      end
      3'd2: begin
        if (sym_q[1:0] == 2'b01) begin
          hit  = 1'b1;
          code = 3'd0;
        end
      end
      3'd3: begin
        case (sym_q[2:0])
          3'b100:  begin hit = 1'b1; code = 3'd3; end
          3'b110:  begin hit = 1'b1; code = 3'd6; end
          default: ;
        endcase
      end
      3'd4: begin
        case (sym_q)
          4'b1000: begin hit = 1'b1; code = 3'd1; end
          4'b1010: begin hit = 1'b1; code = 3'd2; end
          4'b0010: begin hit = 1'b1; code = 3'd5; end
          4'b0000: begin hit = 1'b1; code = 3'd7; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    s1_d     = morse_in;
    s2_d     = s1_q;
    primed_d = 1'b1;
    // Arm only once the synchronizer holds real samples, so a key held
    // through reset release is not mistaken for a fresh press.
    armed_d  = armed_q | (primed_q & ~s1_q & ~s2_q);
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    n_d      = n_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m && armed_q) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end
      end
      MARK: begin
        if (m) begin
          cnt_d = cnt_inc;
        end else begin
          if (n_q == 3'd4) begin
            ovf_d = 1'b1;
          end else begin
            sym_d = {sym_q[2:0], is_dash};
            n_d   = n_q + 3'd1;
          end
          state_d = SPACE;
          cnt_d   = CNT_ONE;
        end
      end
      SPACE: begin
        if (cnt_q == GAP_END) begin
          if (hit && !ovf_q) begin
            letter_d = code;
            valid_d  = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
          sym_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
        end else if (m) begin
          state_d = MARK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      primed_q <= 1'b0;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      sym_q    <= '0;
      n_q      <= '0;
      ovf_q    <= 1'b0;
      letter_q <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      primed_q <= primed_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      n_q      <= n_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = valid_q;
  assign letter_error = error_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: vector table, corner sequences, random letters
// checked against a string-level Morse model.
module tb_morse_decoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       morse_in = 1'b0;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  int nerr = 0;
  int nchk = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;

  morse_decoder #(.UNIT_CYCLES(U), .CNT_W(16)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .morse_in     (morse_in),
    .letter       (letter),
    .letter_valid (letter_valid),
    .letter_error (letter_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (letter_valid) vcnt++;
    if (letter_error) ecnt++;
    if (letter_valid && letter_error) both++;
  end

  string morse_tab [8] = '{".-", "-...", "-.-.", "-..",
                           ".", "..-.", "--.", "...."};

  function automatic int lookup(string s);
    for (int i = 0; i < 8; i++)
      if (s == morse_tab[i]) return i;
    return -1;
  endfunction

  task automatic check(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(int h, int l);
    morse_in = 1'b1;
    step(h);
    morse_in = 1'b0;
    step(l);
  endtask

  task automatic play(string p);
    for (int i = 0; i < p.len(); i++)
      key((p[i] == "-") ? 2 * U : 2, (i == p.len() - 1) ? 3 * U : U);
    step(4);
  endtask

  typedef struct {
    string      pat;
    logic       ok;
    logic [2:0] let_exp;
  } vec_t;

  vec_t vt [11];

  initial begin
    int v0, e0, first, busy_hit, busy_pre, after;
    string s;
    int exp_letter, ns, h, g, idx;

    vt[0]  = '{".",     1'b1, 3'd4};
    vt[1]  = '{"-",     1'b0, 3'd4};
    vt[2]  = '{"....",  1'b1, 3'd7};
    vt[3]  = '{"-..",   1'b1, 3'd3};
    vt[4]  = '{"--.",   1'b1, 3'd6};
    vt[5]  = '{"..-.",  1'b1, 3'd5};
    vt[6]  = '{"---",   1'b0, 3'd5};
    vt[7]  = '{"-.-.",  1'b1, 3'd2};
    vt[8]  = '{"-...",  1'b1, 3'd1};
    vt[9]  = '{".....", 1'b0, 3'd1};
    vt[10] = '{".-",    1'b1, 3'd0};

    step(2);
    check("rst_letter", letter, 0);
    check("rst_valid", letter_valid, 0);
    check("rst_error", letter_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step(5);

    // A with timing: high 3, low 4, high 8, final fall
    key(3, 4);
    morse_in = 1'b1;
    step(8);
    morse_in = 1'b0;
    first = 0; busy_hit = 1; busy_pre = 0; after = 1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 14) busy_pre = busy;
      if (letter_valid && first == 0) begin
        first = k;
        busy_hit = busy;
      end
      if (k == 16) after = letter_valid;
    end
    check("a_latency", first, 3 * U + 1 + 2);
    check("a_busy_pre", busy_pre, 1);
    check("a_busy_at_pulse", busy_hit, 0);
    check("a_pulse_width", after, 0);
    check("a_letter", letter, 0);

    foreach (vt[i]) begin
      v0 = vcnt; e0 = ecnt;
      play(vt[i].pat);
      check({"vec_valid ", vt[i].pat}, vcnt - v0, vt[i].ok ? 1 : 0);
      check({"vec_error ", vt[i].pat}, ecnt - e0, vt[i].ok ? 0 : 1);
      check({"vec_letter ", vt[i].pat}, letter, vt[i].let_exp);
    end

    // dot/dash boundary
    v0 = vcnt; e0 = ecnt;
    key(2 * U - 1, 3 * U); step(4);
    check("bnd_dot_valid", vcnt - v0, 1);
    check("bnd_dot_letter", letter, 4);
    v0 = vcnt; e0 = ecnt;
    key(2 * U, 3 * U); step(4);
    check("bnd_dash_error", ecnt - e0, 1);
    check("bnd_dash_valid", vcnt - v0, 0);
    check("bnd_dash_letter", letter, 4);

    // gap boundary: 11 low keeps letter together
    v0 = vcnt; e0 = ecnt;
    key(2, 3 * U - 1);
    key(2 * U, 3 * U); step(4);
    check("gap_valid", vcnt - v0, 1);
    check("gap_error", ecnt - e0, 0);
    check("gap_letter", letter, 0);

    // reset mid-B
    v0 = vcnt; e0 = ecnt;
    key(2 * U, U);
    key(2, 2);
    reset = 1'b1; step(1); reset = 1'b0;
    busy_hit = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      busy_hit |= busy;
    end
    check("rstmid_pulses", (vcnt - v0) + (ecnt - e0), 0);
    check("rstmid_busy", busy_hit, 0);
    check("rstmid_letter", letter, 0);
    v0 = vcnt;
    play("-.-.");
    check("rstmid_c_valid", vcnt - v0, 1);
    check("rstmid_c_letter", letter, 2);

    // key held across reset release
    v0 = vcnt; e0 = ecnt;
    morse_in = 1'b1;
    reset = 1'b1; step(2); reset = 1'b0;
    busy_hit = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      busy_hit |= busy;
    end
    morse_in = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      busy_hit |= busy;
    end
    check("hold_pulses", (vcnt - v0) + (ecnt - e0), 0);
    check("hold_busy", busy_hit, 0);
    exp_letter = 0;
    check("hold_letter", letter, exp_letter);

    // random letters vs string model
    for (int t = 0; t < 40; t++) begin
      v0 = vcnt; e0 = ecnt;
      s = "";
      ns = $urandom_range(5, 1);
      for (int j = 0; j < ns; j++) begin
        h = $urandom_range(14, 1);
        s = {s, (h >= 2 * U) ? "-" : "."};
        g = (j == ns - 1) ? $urandom_range(3 * U + 4, 3 * U)
                          : $urandom_range(3 * U - 1, 1);
        key(h, g);
      end
      step(4);
      idx = lookup(s);
      if (idx >= 0) exp_letter = idx;
      check({"rnd_valid ", s}, vcnt - v0, (idx >= 0) ? 1 : 0);
      check({"rnd_error ", s}, ecnt - e0, (idx >= 0) ? 0 : 1);
      check({"rnd_letter ", s}, letter, exp_letter);
    end

    check("never_both", both, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
